// File: rtl/shr_seq.sv
// shr_seq: multi-cycle 16-bit srl/sra/ror unit, one binary shift stage (1/2/4/8) per clock.
// Define SHR_EARLY_EXIT_EN to leave SHIFT once no higher count bits remain.
//   state | meaning
//   IDLE  | waiting for start, out holds last result
//   SHIFT | applying stage k = stage_q, busy high
//   DONE  | result final, done high, start accepted back-to-back
module shr_seq (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] in_i,
  input  logic [3:0]  cnt_i,
  input  logic [1:0]  op_i,
  output logic [15:0] out_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] data_q;
  logic [3:0]  cnt_q;
  logic [1:0]  op_q;
  logic [1:0]  stage_q;

  logic [15:0] data_d;
  logic        last_stage;
  logic        skip_shift;

  function automatic logic [15:0] shift_stage(input logic [15:0] d,
                                              input logic [1:0]  op,
                                              input logic [1:0]  k);
    logic [4:0] s;
    s = 5'd1 << k;
    case (op)
      2'b01:   shift_stage = $signed(d) >>> s;
      2'b10:   shift_stage = (d >> s) | (d << (5'd16 - s));
      default: shift_stage = d >> s;
    endcase
  endfunction

  always_comb begin
    data_d = data_q;
    if (cnt_q[stage_q]) data_d = shift_stage(data_q, op_q, stage_q);
  end

`ifdef SHR_EARLY_EXIT_EN
  // Remaining stages are no-ops once every count bit above the current one is clear.
  assign last_stage = (((cnt_q >> stage_q) >> 1) == 4'd0);
  assign skip_shift = (cnt_i == 4'd0);
`else
  assign last_stage = (stage_q == 2'd3);
  assign skip_shift = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      data_q  <= 16'h0000;
      cnt_q   <= 4'h0;
      op_q    <= 2'b00;
      stage_q <= 2'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            data_q  <= in_i;
            cnt_q   <= cnt_i;
            op_q    <= op_i;
            stage_q <= 2'd0;
            state_q <= skip_shift ? DONE : SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          data_q  <= data_d;
          stage_q <= stage_q + 2'd1;
          if (last_stage) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_o  = data_q;
  assign busy_o = (state_q == SHIFT);
  assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_shr_seq.sv
// tb_shr_seq: directed and randomized checks of shr_seq against a whole-count shift model.
module tb_shr_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] in_v;
  logic [3:0]  cnt_v;
  logic [1:0]  op_v;
  logic [15:0] out_v;
  logic        busy_v;
  logic        done_v;

  int n_pass;
  int n_total;

  shr_seq dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .in_i    (in_v),
    .cnt_i   (cnt_v),
    .op_i    (op_v),
    .out_o   (out_v),
    .busy_o  (busy_v),
    .done_o  (done_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [15:0] a, input logic [3:0] c,
                                        input logic [1:0] o);
    logic [31:0] dbl;
    case (o)
      2'b01: model = $signed(a) >>> c;
      2'b10: begin
        dbl   = {a, a} >> c;
        model = dbl[15:0];
      end
      default: model = a >> c;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] c);
`ifdef SHR_EARLY_EXIT_EN
    int h;
    h = 0;
    for (int i = 0; i < 4; i++) if (c[i]) h = i + 1;
    exp_lat = 1 + h;
`else
    exp_lat = 5;
`endif
  endfunction

  // Called at a negedge; returns at a negedge. Optionally pulses a stray start in SHIFT.
  task automatic run_op(input logic [15:0] a, input logic [3:0] c, input logic [1:0] o,
                        input int inject_cyc, input bit stop_at_done, input string name);
    logic [15:0] exp;
    logic [15:0] out_at_done;
    int lat, done_cyc, done_n, busy_n;
    exp = model(a, c, o);
    lat = exp_lat(c);
    done_cyc = 0;
    done_n = 0;
    busy_n = 0;
    out_at_done = 'x;
    start = 1'b1;
    in_v  = a;
    cnt_v = c;
    op_v  = o;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (busy_v === 1'b1) busy_n++;
      if (done_v === 1'b1) begin
        done_n++;
        if (done_cyc == 0) begin
          done_cyc = k;
          out_at_done = out_v;
        end
      end
      if (inject_cyc != 0 && k == inject_cyc) begin
        start = 1'b1;
        in_v  = 16'hFFFF;
        cnt_v = 4'($urandom);
        op_v  = 2'($urandom);
      end else begin
        start = 1'b0;
      end
      if (stop_at_done && done_cyc != 0) break;
    end
    n_total++;
    if (out_at_done !== exp)
      $display("FAIL %s result: got %h expected %h", name, out_at_done, exp);
    else n_pass++;
    n_total++;
    if (done_cyc !== lat)
      $display("FAIL %s done_latency: got %0d expected %0d", name, done_cyc, lat);
    else n_pass++;
    n_total++;
    if (done_n !== 1)
      $display("FAIL %s done_pulses: got %0d expected 1", name, done_n);
    else n_pass++;
    n_total++;
    if (busy_n !== lat - 1)
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_n, lat - 1);
    else n_pass++;
    if (!stop_at_done) begin
      n_total++;
      if (out_v !== exp)
        $display("FAIL %s out_hold: got %h expected %h", name, out_v, exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    in_v  = 16'h0;
    cnt_v = 4'h0;
    op_v  = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (out_v !== 16'h0000) $display("FAIL reset_out: got %h expected 0000", out_v);
    else n_pass++;
    n_total++;
    if (busy_v !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_v);
    else n_pass++;
    n_total++;
    if (done_v !== 1'b0) $display("FAIL reset_done: got %b expected 0", done_v);
    else n_pass++;
  endtask

  task automatic test_directed();
    run_op(16'h8001, 4'd1,  2'b00, 0, 1'b0, "srl_8001_1");
    run_op(16'h8000, 4'd15, 2'b01, 0, 1'b0, "sra_8000_15");
    run_op(16'h7FF0, 4'd4,  2'b01, 0, 1'b0, "sra_7ff0_4");
    run_op(16'h1234, 4'd4,  2'b10, 0, 1'b0, "ror_1234_4");
    run_op(16'h0001, 4'd15, 2'b10, 0, 1'b0, "ror_0001_15");
    run_op(16'hF000, 4'd8,  2'b11, 0, 1'b0, "rsv_f000_8");
  endtask

  task automatic test_ignore_start();
    run_op(16'h00FF, 4'd2, 2'b00, 2, 1'b0, "ignore_start");
  endtask

  task automatic test_back_to_back();
    run_op(16'h1234, 4'd4, 2'b10, 0, 1'b1, "b2b_first");
    run_op(16'h0100, 4'd8, 2'b00, 0, 1'b0, "b2b_second");
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    in_v  = 16'hBEEF;
    cnt_v = 4'd9;
    op_v  = 2'b01;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (out_v !== 16'h0000) $display("FAIL rst_mid_out: got %h expected 0000", out_v);
    else n_pass++;
    n_total++;
    if (busy_v !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy_v);
    else n_pass++;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
        if (done_v !== 1'b0) seen++;
        @(negedge clk);
      end
      n_total++;
      if (seen !== 0) $display("FAIL rst_mid_no_done: got %0d pulses expected 0", seen);
      else n_pass++;
    end
    run_op(16'hC3C3, 4'd3, 2'b01, 0, 1'b0, "after_rst_mid");
  endtask

  task automatic test_cnt_zero();
    run_op(16'hA5A5, 4'd0, 2'b00, 0, 1'b0, "cnt_zero_srl");
    run_op(16'h8421, 4'd0, 2'b10, 0, 1'b1, "cnt_zero_b2b");
    run_op(16'h8421, 4'd0, 2'b01, 0, 1'b0, "cnt_zero_sra");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic [15:0] a;
      logic [3:0]  c;
      logic [1:0]  o;
      int inj;
      a = 16'($urandom);
      c = 4'($urandom);
      o = 2'($urandom);
      inj = (exp_lat(c) >= 2 && $urandom_range(0, 1) == 1) ? 1 : 0;
      run_op(a, c, o, inj, (i % 4 == 3), $sformatf("rand_%0d", i));
    end
    run_op(16'h0F0F, 4'd7, 2'b10, 0, 1'b0, "rand_tail");
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b0;
    start   = 1'b0;
    in_v    = 16'h0;
    cnt_v   = 4'h0;
    op_v    = 2'b00;
    @(negedge clk);
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_cnt_zero();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shr_seq.md
# shr_seq

Multi-cycle 16-bit right-shift/rotate unit for the execute stage, the right-direction counterpart of the combinational left-logical shifter. It accepts an operand, a 4-bit count and an opcode on a start pulse. It applies the 1/2/4/8 shift stages one per clock from an internal data register and signals completion with a one-cycle `done` pulse. The result is held stable until the next accepted start. The execute-stage controller stalls on `busy`.

## Interface
- No parameters; data width is fixed at 16, count width at 4.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when state is IDLE or DONE.
- `in`  in  16  operand, captured on accepted start.
- `cnt`  in  4  shift amount 0–15, captured on accepted start.
- `op`  in  2  00 = srl, 01 = sra, 10 = ror, 11 = reserved (executes as srl); captured on accepted start.
- `out`  out  16  result register.
- `busy`  out  1  high while state is SHIFT.
- `done`  out  1  high for exactly one cycle when the result is final.

## Operation
- States: IDLE, SHIFT, DONE. Registers: `data[15:0]`, `cnt_q[3:0]`, `op_q[1:0]`, `stage[1:0]`. `out` is driven directly from `data`.
- IDLE
  - `start`=1 → load `data`←`in`, `cnt_q`←`cnt`, `op_q`←`op`, `stage`←0; go to SHIFT.
  - Otherwise remain in IDLE.
- SHIFT, each cycle:
  - Let k = `stage`. If `cnt_q[k]`=1, shift `data` right by 2^k; otherwise `data` is unchanged.
  - Fill for srl: zeros.
  - Fill for sra: `data[15]`. The sign is preserved through every stage.
  - ror: the bits shifted out re-enter at the MSB end.
  - `stage` increments each cycle. After stage 3 completes, go to DONE.
- DONE
  - `done`=1 for this cycle only.
  - `start`=1 → accept exactly as in IDLE (back-to-back operation); go to SHIFT.
  - Otherwise go to IDLE.
- `start` while in SHIFT is ignored and has no effect on any register.
- `cnt`=0: the SHIFT stages still run, and `out` equals the captured `in`.
- Reset at any time, including mid-SHIFT:
  - Next state is IDLE.
  - `data`, `cnt_q`, `op_q` and `stage` are all cleared to 0.
  - Any in-flight operation is discarded and no `done` is generated for it.

## Timing
- Reset values: `out`=0x0000, `busy`=0, `done`=0, state IDLE.
- An accepted start is sampled in cycle N, with registers loaded at the edge ending cycle N.
- `busy`=1 during cycles N+1..N+4.
- `done`=1 and `out` is final in cycle N+5 (fixed latency of 5 cycles from start to done).
- `out` is updated only at the capture edge and at SHIFT edges. Its intermediate values during SHIFT are not architecturally meaningful.
- `out` holds its final value through DONE and IDLE until the capture edge of the next accepted start.
- A start accepted in the DONE cycle (N+5) makes the next `done` appear at N+10. `done` never stays high two consecutive cycles.

## Configuration
- `SHR_EARLY_EXIT_EN`
  - Defined: SHIFT exits to DONE as soon as all remaining `cnt_q` bits above the current stage are zero. Let h = index of the highest set bit of `cnt` plus 1, with h=0 when `cnt`=0.
    - `done` occurs in cycle N+1+h.
    - `cnt`=0 goes from capture directly to DONE: `done` in cycle N+1, and `busy` never asserts.
    - `cnt`=1 gives `done` at N+2. `cnt`≥8 gives `done` at N+5.
  - Undefined: fixed 4-stage SHIFT, with `done` always at N+5.
  - Results are identical in both builds.

## Test plan
- Reset, then srl `in`=0x8001 `cnt`=1 → `busy` high 4 cycles; `done` at N+5 with `out`=0x4000.
- sra `in`=0x8000 `cnt`=15 → `out`=0xFFFF. sra `in`=0x7FF0 `cnt`=4 → `out`=0x07FF.
- ror `in`=0x1234 `cnt`=4 → `out`=0x4123. ror `in`=0x0001 `cnt`=15 → `out`=0x0002. op=11 `in`=0xF000 `cnt`=8 → `out`=0x00F0.
- Pulse `start` with `in`=0xFFFF during SHIFT of a srl 0x00FF `cnt`=2 → pulse is ignored; `out`=0x003F; exactly one `done`.
- Start in the DONE cycle with srl 0x0100 `cnt`=8 → second `done` 5 cycles later with `out`=0x0001. Then assert `rst` mid-SHIFT of another op → `out`=0, `busy`=0, no `done`.
- `cnt`=0 `in`=0xA5A5 → `out`=0xA5A5. `done` is at N+5 without the macro; with `SHR_EARLY_EXIT_EN`, `done` is at N+1 with `busy` never asserted.
